lif_pot_update: RTL and testbench
=================================

// Module: lif_pot_update
// PURPOSE
//  Read-modify-write engine for membrane potentials held in bram_pot (1-cycle read latency, no reset on contents).
//  Accumulates weighted input events into per-neuron potentials during a timestep.
//  On step_start, sweeps all neurons: applies leak, fires against a threshold, resets the potential and emits spike addresses.
//  Sits between the synapse/weight fetch stage (upstream) and the spike router (downstream).
// PARAMETERS
//  N_NEURONS      32                   neurons (= bram_pot RAM_DEPTH)
//  ADDR_W         $clog2(N_NEURONS)    potential address width
//  LEAK_SHIFT     4                    leak = v >>> LEAK_SHIFT (arithmetic)
//  SPK_FIFO_DEPTH 4                    output spike FIFO entries (power of 2, >= 4)
// PORTS
//  clk        in  1       clock
//  rst        in  1       asynchronous reset, active-low
//  in_valid   in  1       input event valid
//  in_ready   out 1       event accepted when in_valid & in_ready
//  in_addr    in  ADDR_W  target neuron
//  in_weight  in  32      signed Q16.16 weight
//  step_start in  1       1-cycle pulse: end of accumulation, begin sweep
//  thresh     in  32      signed Q16.16 firing threshold; sampled at step_start
//  mem_ren    out 1       -> bram_pot ren
//  mem_raddr  out ADDR_W  -> bram_pot raddr
//  mem_rdat   in  32      <- bram_pot rdat (valid cycle after mem_ren)
//  mem_wren   out 1       -> bram_pot wren
//  mem_wraddr out ADDR_W  -> bram_pot wraddr
//  mem_wrdat  out 32      -> bram_pot wrdat
//  spk_valid  out 1       spike address available
//  spk_ready  in  1       downstream accepts spike
//  spk_addr   out ADDR_W  firing neuron index
//  busy       out 1       state != IDLE or pipeline non-empty
//  step_done  out 1       1-cycle pulse: last sweep write issued
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, FIFO empty, pipeline flushed; mid-operation reset aborts sweep, memory untouched.
//  Pipeline: S0 issue read (mem_ren, mem_raddr) | S1 mem_rdat valid, compute | S2 registered write (mem_wren=1).
//  Event accept->write: 2 cycles; throughput 1 event/cycle, in_ready=1 in IDLE/ACCUM.
//  Hazard: S1 operand forwarded from S2 write if same addr, else from S3 (write retired last cycle); S2 wins.
//  Accumulate: v' = sat32(v + w), saturating to 0x7FFF_FFFF / 0x8000_0000.
//  FSM: IDLE -(in accept)-> ACCUM; IDLE/ACCUM -(step_start)-> DRAIN; DRAIN -(pipeline empty)-> SWEEP;
//       SWEEP -(addr N_NEURONS-1 issued)-> FLUSH; FLUSH -(pipeline empty)-> IDLE with step_done=1.
//  step_start same cycle as in_valid: event is accepted and included in this step. step_start outside IDLE/ACCUM ignored.
//  DRAIN/SWEEP/FLUSH: in_ready=0.
//  Sweep: addresses 0..N_NEURONS-1 ascending; vl = v - (v >>> LEAK_SHIFT); fire = (vl >= thresh) signed.
//  Fire -> push addr into spike FIFO; write reset value; else write vl.
//  Sweep issue stalls while FIFO free slots <= in-flight sweep reads (no spike ever dropped).
//  FIFO: spk_valid = !empty; pop on spk_valid & spk_ready; simultaneous push/pop at full allowed.
//  Spikes may remain in FIFO after step_done; next step_start accepted regardless.
// CONFIGURATION
//  LIF_SOFT_RESET_EN defined: fired neuron written sat32(vl - thresh) (residual kept).
//  Not defined: fired neuron written 0 (hard reset).
// STRUCTURE
//  snn_pkg: pot_t (logic signed [31:0]), lif_state_e {IDLE,ACCUM,DRAIN,SWEEP,FLUSH}, sat_add32()/sat_sub32() functions.
//  Sub-module: lif_spike_fifo (sync FIFO, DEPTH=SPK_FIFO_DEPTH, WIDTH=ADDR_W, count output).
//  Bench instantiates bram_pot (no SIM define, 32-bit vector) behind this block.
// TESTING
//  1. Events (3,+1.0),(3,+2.0),(3,+0.5) back-to-back from 0 -> addr3 = 0x0003_8000; forwarding exercised at S2 and S3.
//  2. addr5=0x7FFF_0000 then event +2.0 -> addr5 saturates to 0x7FFF_FFFF.
//  3. addr7=2.0, thresh=1.0, LEAK_SHIFT=4, step_start -> vl=1.875, spike 7, addr7=0 (0x0000_E000 with LIF_SOFT_RESET_EN).
//  4. All 32 neurons 2.0, thresh=1.0, spk_ready=0 -> 4 spikes queued, sweep stalls; release -> 32 spikes 0..31 in order, step_done once.
//  5. step_start with in_valid same cycle, addr9 event 1.5, thresh 1.0 -> event included, spike 9 emitted.
//  6. rst asserted mid-SWEEP -> all outputs 0 immediately; after release in_ready=1, busy=0, no stale spikes.

Source files
------------

// File: rtl/snn_pkg.sv
// Shared types and saturating arithmetic for the LIF potential datapath.
// Potentials and weights are signed Q16.16 held in 32 bits.
package snn_pkg;

  typedef logic signed [31:0] pot_t;

  typedef enum logic [2:0] {
    IDLE,
    ACCUM,
    DRAIN,
    SWEEP,
    FLUSH
  } lif_state_e;

  localparam pot_t POT_MAX = 32'h7FFF_FFFF;
  localparam pot_t POT_MIN = 32'h8000_0000;

  // a + b clamped to the signed 32-bit range
  function automatic pot_t sat_add32(input pot_t a, input pot_t b);
    logic signed [32:0] s;
    s = {a[31], a} + {b[31], b};
    if (s[32] != s[31]) return s[32] ? POT_MIN : POT_MAX;
    return s[31:0];
  endfunction

  // a - b clamped to the signed 32-bit range
  function automatic pot_t sat_sub32(input pot_t a, input pot_t b);
    logic signed [32:0] s;
    s = {a[31], a} - {b[31], b};
    if (s[32] != s[31]) return s[32] ? POT_MIN : POT_MAX;
    return s[31:0];
  endfunction

endpackage

// File: rtl/bram_pot.sv
// Simple dual-port potential RAM, one-cycle registered read, read-first on
// a same-address read/write collision. Contents are not reset.
module bram_pot #(
  parameter int RAM_DEPTH = 32,
  parameter int ADDR_W    = $clog2(RAM_DEPTH),
  parameter int DATA_W    = 32
) (
  input  logic              clk,
  input  logic              ren_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdat_o,
  input  logic              wren_i,
  input  logic [ADDR_W-1:0] wraddr_i,
  input  logic [DATA_W-1:0] wrdat_i
);

  logic [DATA_W-1:0] mem_q [RAM_DEPTH];

  // Write port and registered read port.
  always_ff @(posedge clk) begin
    if (wren_i) mem_q[wraddr_i] <= wrdat_i;
    if (ren_i)  rdat_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/lif_spike_fifo.sv
// Synchronous spike-address FIFO. DEPTH must be a power of two so the
// pointers wrap naturally. A push while full is accepted when a pop
// happens in the same cycle.
module lif_spike_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             full, do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full || do_pop);
  assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Storage array: written on push only.
  // NOTE: the storage has no reset; occupancy is tracked by the pointers/count, so clearing it would only cost logic.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  // Pointer and occupancy bookkeeping.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/lif_pot_update.sv
// Membrane-potential read-modify-write engine.
// Accumulates weighted events into potentials, then on step_start sweeps
// every neuron applying leak and fire/reset, pushing spike addresses into
// a small FIFO. Pipeline: S0 read issue, S1 compute on RAM data, S2 write.
// Build option LIF_SOFT_RESET_EN: fired neurons keep the residual
// (vl - thresh) instead of being cleared to zero.
module lif_pot_update
  import snn_pkg::*;
#(
  parameter int N_NEURONS      = 32,
  parameter int ADDR_W         = $clog2(N_NEURONS),
  parameter int LEAK_SHIFT     = 4,
  parameter int SPK_FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [ADDR_W-1:0] in_addr_i,
  input  logic [31:0]       in_weight_i,
  input  logic              step_start_i,
  input  logic [31:0]       thresh_i,
  output logic              mem_ren_o,
  output logic [ADDR_W-1:0] mem_raddr_o,
  input  logic [31:0]       mem_rdat_i,
  output logic              mem_wren_o,
  output logic [ADDR_W-1:0] mem_wraddr_o,
  output logic [31:0]       mem_wrdat_o,
  output logic              spk_valid_o,
  input  logic              spk_ready_i,
  output logic [ADDR_W-1:0] spk_addr_o,
  output logic              busy_o,
  output logic              step_done_o
);

  localparam int                CNT_W     = $clog2(SPK_FIFO_DEPTH) + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_NEURONS - 1);

  // Control state
  lif_state_e        state_q;
  logic              in_ready_q, step_done_q;
  logic [ADDR_W-1:0] sweep_addr_q;
  pot_t              thresh_q;

  // S1: read returned this cycle, compute
  logic              s1_valid_q, s1_sweep_q;
  logic [ADDR_W-1:0] s1_addr_q;
  pot_t              s1_weight_q;

  // S2: write to RAM; S3: write retired last cycle (forwarding only)
  logic              s2_valid_q, s3_valid_q;
  logic [ADDR_W-1:0] s2_addr_q, s3_addr_q;
  pot_t              s2_data_q, s3_data_q;

  logic              in_accept, sweep_room, sweep_issue, pipe_busy;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_empty;
  pot_t              v_s1, vl_s1, res_s1, reset_val;
  logic              fire_s1;

  assign in_accept   = in_valid_i && in_ready_q;
  assign pipe_busy   = s1_valid_q || s2_valid_q;
  // A sweep read may only issue if its spike is guaranteed a FIFO slot,
  // counting the sweep op already in S1 that may still push.
  assign sweep_room  = (int'(fifo_count) + int'(s1_sweep_q)) < SPK_FIFO_DEPTH;
  assign sweep_issue = (state_q == SWEEP) && sweep_room;

  assign mem_ren_o   = in_accept || sweep_issue;
  assign mem_raddr_o = sweep_issue ? sweep_addr_q : (in_accept ? in_addr_i : '0);

  // Control FSM: accumulate, drain, leak/fire sweep, flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      in_ready_q   <= 1'b0;
      step_done_q  <= 1'b0;
      sweep_addr_q <= '0;
      thresh_q     <= '0;
    end else begin
      step_done_q <= 1'b0;
      case (state_q)
        IDLE, ACCUM: begin
          if (step_start_i) begin
            state_q    <= DRAIN;
            in_ready_q <= 1'b0;
            thresh_q   <= thresh_i;
          end else begin
            in_ready_q <= 1'b1;
            if (in_accept) state_q <= ACCUM;
          end
        end
        DRAIN: begin
          if (!pipe_busy) begin
            state_q      <= SWEEP;
            sweep_addr_q <= '0;
          end
        end
        SWEEP: begin
          if (sweep_issue) begin
            sweep_addr_q <= sweep_addr_q + ADDR_W'(1);
            if (sweep_addr_q == LAST_ADDR) state_q <= FLUSH;
          end
        end
        FLUSH: begin
          if (!pipe_busy) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            step_done_q <= 1'b1;
          end
        end
        default: begin
          state_q    <= IDLE;
          in_ready_q <= 1'b0;
        end
      endcase
    end
  end

  // S1 operand select: RAM data, overridden by S3 then S2 (newest wins).
  // NOTE: the default assignment first keeps this block purely combinational (no latch).
  always_comb begin
    v_s1 = pot_t'(mem_rdat_i);
    if (s3_valid_q && (s3_addr_q == s1_addr_q)) v_s1 = s3_data_q;
    if (s2_valid_q && (s2_addr_q == s1_addr_q)) v_s1 = s2_data_q;
  end

  assign vl_s1   = v_s1 - (v_s1 >>> LEAK_SHIFT);
  assign fire_s1 = s1_sweep_q && (vl_s1 >= thresh_q);

`ifdef LIF_SOFT_RESET_EN
  assign reset_val = sat_sub32(vl_s1, thresh_q);
`else
  assign reset_val = '0;
`endif

  assign res_s1 = s1_sweep_q ? (fire_s1 ? reset_val : vl_s1)
                             : sat_add32(v_s1, s1_weight_q);

  // Pipeline registers S1 -> S2 -> S3.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_sweep_q  <= 1'b0;
      s1_addr_q   <= '0;
      s1_weight_q <= '0;
      s2_valid_q  <= 1'b0;
      s2_addr_q   <= '0;
      s2_data_q   <= '0;
      s3_valid_q  <= 1'b0;
      s3_addr_q   <= '0;
      s3_data_q   <= '0;
    end else begin
      s1_valid_q  <= mem_ren_o;
      s1_sweep_q  <= sweep_issue;
      s1_addr_q   <= mem_raddr_o;
      s1_weight_q <= in_weight_i;
      s2_valid_q  <= s1_valid_q;
      s2_addr_q   <= s1_addr_q;
      s2_data_q   <= res_s1;
      s3_valid_q  <= s2_valid_q;
      s3_addr_q   <= s2_addr_q;
      s3_data_q   <= s2_data_q;
    end
  end

  lif_spike_fifo #(
    .DEPTH (SPK_FIFO_DEPTH),
    .WIDTH (ADDR_W)
  ) u_spike_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (fire_s1),
    .data_i  (s1_addr_q),
    .pop_i   (spk_ready_i),
    .data_o  (spk_addr_o),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign in_ready_o   = in_ready_q;
  assign mem_wren_o   = s2_valid_q;
  assign mem_wraddr_o = s2_addr_q;
  assign mem_wrdat_o  = s2_data_q;
  assign spk_valid_o  = !fifo_empty;
  assign busy_o       = (state_q != IDLE) || pipe_busy;
  assign step_done_o  = step_done_q;

endmodule

// File: tb/tb_lif_pot_update.sv
// Bench for lif_pot_update with a bram_pot behind it. A potential-array
// model predicts every RAM write and every spike; literal expectations pin
// the model on the key scenarios.
module tb_lif_pot_update;

`ifdef LIF_SOFT_RESET_EN
  localparam bit SOFT = 1'b1;
`else
  localparam bit SOFT = 1'b0;
`endif

  logic        clk, rst_n;
  logic        in_valid, in_ready, step_start, spk_valid, spk_ready, busy, step_done;
  logic [4:0]  in_addr, mem_raddr, mem_wraddr, spk_addr;
  logic [31:0] in_weight, thresh, mem_rdat, mem_wrdat;
  logic        mem_ren, mem_wren;

  // Backdoor preload port, only used while the DUT is not writing
  logic        bd_we;
  logic [4:0]  bd_addr;
  logic [31:0] bd_data;
  logic        ram_we;
  logic [4:0]  ram_waddr;
  logic [31:0] ram_wdat;

  assign ram_we    = mem_wren | bd_we;
  assign ram_waddr = bd_we ? bd_addr : mem_wraddr;
  assign ram_wdat  = bd_we ? bd_data : mem_wrdat;

  lif_pot_update u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .in_addr_i    (in_addr),
    .in_weight_i  (in_weight),
    .step_start_i (step_start),
    .thresh_i     (thresh),
    .mem_ren_o    (mem_ren),
    .mem_raddr_o  (mem_raddr),
    .mem_rdat_i   (mem_rdat),
    .mem_wren_o   (mem_wren),
    .mem_wraddr_o (mem_wraddr),
    .mem_wrdat_o  (mem_wrdat),
    .spk_valid_o  (spk_valid),
    .spk_ready_i  (spk_ready),
    .spk_addr_o   (spk_addr),
    .busy_o       (busy),
    .step_done_o  (step_done)
  );

  bram_pot #(.RAM_DEPTH(32)) u_ram (
    .clk      (clk),
    .ren_i    (mem_ren),
    .raddr_i  (mem_raddr),
    .rdat_o   (mem_rdat),
    .wren_i   (ram_we),
    .wraddr_i (ram_waddr),
    .wrdat_i  (ram_wdat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int wr_cnt   = 0;
  int spk_cnt  = 0;
  int done_cnt = 0;
  logic [31:0] last_spk = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;

  logic [31:0] model_mem [32];
  wr_t         wq [$];
  int          sq [$];

  function automatic logic [31:0] m_sat(input longint x);
    if (x > 64'sd2147483647)  return 32'h7FFF_FFFF;
    if (x < -64'sd2147483648) return 32'h8000_0000;
    return x[31:0];
  endfunction

  task automatic m_accum(input int a, input logic [31:0] w);
    model_mem[a] = m_sat(longint'($signed(model_mem[a])) + longint'($signed(w)));
    wq.push_back({5'(a), model_mem[a]});
  endtask

  task automatic m_sweep(input logic [31:0] t);
    longint      tv, v, vl;
    logic [31:0] nv;
    tv = longint'($signed(t));
    for (int i = 0; i < 32; i++) begin
      v  = longint'($signed(model_mem[i]));
      vl = v - (v >>> 4);
      if (vl >= tv) begin
        sq.push_back(i);
        nv = SOFT ? m_sat(vl - tv) : 32'h0;
      end else begin
        nv = vl[31:0];
      end
      model_mem[i] = nv;
      wq.push_back({5'(i), nv});
    end
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin : cmp
    wr_t e;
    if (rst_n) begin
      if (mem_wren) begin
        wr_cnt++;
        check("write_expected", 32'(wq.size() != 0), 32'd1);
        if (wq.size() != 0) begin
          e = wq.pop_front();
          check("wr_addr", 32'(mem_wraddr), 32'(e.a));
          check("wr_data", mem_wrdat, e.d);
        end
      end
      if (spk_valid && spk_ready) begin
        spk_cnt++;
        last_spk = 32'(spk_addr);
        check("spike_expected", 32'(sq.size() != 0), 32'd1);
        if (sq.size() != 0) check("spk_addr", 32'(spk_addr), 32'(sq.pop_front()));
      end
      if (step_done) done_cnt++;
    end
  end

  // ---------------- drivers (called at posedge+1) ----------------
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bd_write(input int a, input logic [31:0] v);
    bd_we = 1'b1; bd_addr = 5'(a); bd_data = v;
    @(posedge clk); #1;
    bd_we = 1'b0;
    model_mem[a] = v;
  endtask

  task automatic bd_fill(input logic [31:0] v);
    for (int i = 0; i < 32; i++) bd_write(i, v);
  endtask

  task automatic ev(input int a, input logic [31:0] w);
    in_valid = 1'b1; in_addr = 5'(a); in_weight = w;
    @(negedge clk);
    check("in_ready_accum", 32'(in_ready), 32'd1);
    m_accum(a, w);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic step(input logic [31:0] t, input bit with_ev = 1'b0,
                      input int a = 0, input logic [31:0] w = '0);
    step_start = 1'b1; thresh = t;
    if (with_ev) begin
      in_valid = 1'b1; in_addr = 5'(a); in_weight = w;
    end
    @(negedge clk);
    if (with_ev) begin
      check("in_ready_step_ev", 32'(in_ready), 32'd1);
      m_accum(a, w);
    end
    m_sweep(t);
    @(posedge clk); #1;
    step_start = 1'b0; in_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int d0, k;
    d0 = done_cnt; k = 0;
    while (done_cnt == d0 && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    check(name, 32'(done_cnt - d0), 32'd1);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // ---------------- main sequence ----------------
  int s0, w0, d0;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_addr = '0; in_weight = '0;
    step_start = 1'b0; thresh = '0; spk_ready = 1'b1;
    bd_we = 1'b0; bd_addr = '0; bd_data = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_spk_valid", 32'(spk_valid), 32'd0);
    check("rst_mem_ren", 32'(mem_ren), 32'd0);
    check("rst_mem_wren", 32'(mem_wren), 32'd0);
    check("rst_step_done", 32'(step_done), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bd_fill(32'h0);
    @(negedge clk);
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    check("post_rst_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;

    // 1: back-to-back events, S2 forwarding (3,3,3) and S3 forwarding (4,6,4)
    ev(3, 32'h0001_0000);
    ev(3, 32'h0002_0000);
    ev(3, 32'h0000_8000);
    ev(4, 32'h0001_0000);
    ev(6, 32'h0001_0000);
    ev(4, 32'h0001_0000);
    idle(4);
    check("t1_addr3", u_ram.mem_q[3], 32'h0003_8000);
    check("t1_addr4", u_ram.mem_q[4], 32'h0002_0000);
    check("t1_busy_accum", 32'(busy), 32'd1);

    // 2: positive and negative saturation
    bd_write(5, 32'h7FFF_0000);
    bd_write(6, 32'h8001_0000);
    ev(5, 32'h0002_0000);
    ev(6, 32'hFFFE_0000);
    idle(4);
    check("t2_addr5_sat", u_ram.mem_q[5], 32'h7FFF_FFFF);
    check("t2_addr6_sat", u_ram.mem_q[6], 32'h8000_0000);

    // 3: single neuron fires after leak
    bd_fill(32'h0);
    bd_write(7, 32'h0002_0000);
    s0 = spk_cnt;
    step(32'h0001_0000);
    wait_done(300, "t3_step_done");
    idle(3);
    check("t3_spike_count", 32'(spk_cnt - s0), 32'd1);
    check("t3_spike_addr", last_spk, 32'd7);
    check("t3_addr7", u_ram.mem_q[7], SOFT ? 32'h0000_E000 : 32'h0);
    check("t3_busy", 32'(busy), 32'd0);

    // 4: all neurons fire with downstream back-pressure
    bd_fill(32'h0002_0000);
    spk_ready = 1'b0;
    s0 = spk_cnt; w0 = wr_cnt; d0 = done_cnt;
    step(32'h0001_0000);
    idle(20);
    check("t4_stall_writes", 32'(wr_cnt - w0), 32'd4);
    check("t4_spk_valid", 32'(spk_valid), 32'd1);
    check("t4_busy", 32'(busy), 32'd1);
    // step_start and events during the sweep must be ignored
    step_start = 1'b1; thresh = 32'h7FFF_FFFF;
    in_valid = 1'b1; in_addr = 5'd0; in_weight = 32'h0001_0000;
    @(negedge clk);
    check("t4_in_ready_sweep", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    step_start = 1'b0; in_valid = 1'b0;
    idle(5);
    check("t4_still_stalled", 32'(wr_cnt - w0), 32'd4);
    spk_ready = 1'b1;
    wait_done(600, "t4_step_done");
    idle(8);
    check("t4_spike_count", 32'(spk_cnt - s0), 32'd32);
    check("t4_last_spike", last_spk, 32'd31);
    check("t4_done_once", 32'(done_cnt - d0), 32'd1);
    check("t4_addr0", u_ram.mem_q[0], SOFT ? 32'h0000_E000 : 32'h0);

    // 5: event in the same cycle as step_start is included
    bd_fill(32'h0);
    s0 = spk_cnt;
    step(32'h0001_0000, 1'b1, 9, 32'h0001_8000);
    wait_done(300, "t5_step_done");
    idle(3);
    check("t5_spike_count", 32'(spk_cnt - s0), 32'd1);
    check("t5_spike_addr", last_spk, 32'd9);
    check("t5_addr9", u_ram.mem_q[9], SOFT ? 32'h0000_6800 : 32'h0);
    check("t5_writes_drained", 32'(wq.size()), 32'd0);
    check("t5_spikes_drained", 32'(sq.size()), 32'd0);

    // 6: reset in the middle of a stalled sweep
    bd_fill(32'h0002_0000);
    spk_ready = 1'b0;
    step(32'h0001_0000);
    idle(15);
    check("t6_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t6_in_ready", 32'(in_ready), 32'd0);
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_spk_valid", 32'(spk_valid), 32'd0);
    check("t6_spk_addr", 32'(spk_addr), 32'd0);
    check("t6_mem_ren", 32'(mem_ren), 32'd0);
    check("t6_mem_raddr", 32'(mem_raddr), 32'd0);
    check("t6_mem_wren", 32'(mem_wren), 32'd0);
    check("t6_mem_wraddr", 32'(mem_wraddr), 32'd0);
    check("t6_mem_wrdat", mem_wrdat, 32'd0);
    check("t6_step_done", 32'(step_done), 32'd0);
    wq.delete();
    sq.delete();
    idle(2);
    check("t6_addr31_untouched", u_ram.mem_q[31], 32'h0002_0000);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("t6_post_in_ready", 32'(in_ready), 32'd1);
    check("t6_post_busy", 32'(busy), 32'd0);
    check("t6_post_spk_valid", 32'(spk_valid), 32'd0);
    @(posedge clk); #1;
    spk_ready = 1'b1;
    w0 = wr_cnt; s0 = spk_cnt;
    idle(10);
    check("t6_no_writes", 32'(wr_cnt - w0), 32'd0);
    check("t6_no_stale_spikes", 32'(spk_cnt - s0), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
